// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: data/register widths,
// load size encodings and the FSM state type.
package wb_stage_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    LD_B = 2'd0,
    LD_H = 2'd1,
    LD_W = 2'd2,
    LD_D = 2'd3
  } ld_size_e;

  typedef enum logic {
    S_IDLE      = 1'b0,
    S_WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load alignment: picks the addressed byte/half/word/doubleword out of an
// 8-byte-aligned bus doubleword and sign- or zero-extends it to 64 bits.
// Ports:
//   rdata       in  64  aligned doubleword from the data bus
//   addr_lo     in  3   load byte address bits [2:0]
//   size        in  2   LD_B/LD_H/LD_W/LD_D
//   is_unsigned in  1   zero-extend instead of sign-extend
//   value       out 64  extended load result
// Misaligned H/W addresses are not trapped here; the sub-size address bits
// are simply dropped, and D ignores addr_lo entirely.
module wb_stage_load_align
  import wb_stage_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [2:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] value
);

  logic [7:0]  b_val;
  logic [15:0] h_val;
  logic [31:0] w_val;

  always_comb begin
    b_val = rdata[{addr_lo, 3'b000} +: 8];
    h_val = rdata[{addr_lo[2:1], 4'b0000} +: 16];
    w_val = rdata[{addr_lo[2], 5'b00000} +: 32];
    value = rdata;
    case (ld_size_e'(size))
      LD_B:    value = {{56{~is_unsigned & b_val[7]}}, b_val};
      LD_H:    value = {{48{~is_unsigned & h_val[15]}}, h_val};
      LD_W:    value = {{32{~is_unsigned & w_val[31]}}, w_val};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: retires LSU results into the single register-file write
// port. Non-loads write one cycle after acceptance; loads park in WAIT_LOAD
// until the data bus returns, then write one cycle after dbus_rvalid.
// The registered (wb_i_rd, wb_i_rf_we, wb_i_rd_dat) triple doubles as the WB
// forwarding broadcast, so x0 is never written.
// Ports:
//   clk, rst                 core clock, async active-high reset
//   lsu_o_*                  retiring instruction offered by the LSU stage
//   wb_o_ready               stage accepts this cycle (IDLE)
//   dbus_rvalid, dbus_rdata  load data return (one-cycle pulse)
//   wb_i_rd/rf_we/rd_dat     register-file write port / WB broadcast
//   wb_o_load_stall          a load is outstanding
//   wb_o_pend_rd             rd of the outstanding load
// Optional feature macro WB_DIFFTEST_EN adds wb_o_commit / wb_o_commit_pc,
// pulsing with the PC on every retiring write cycle.
//
// state       | meaning
// S_IDLE      | ready; accepts any instruction from the LSU
// S_WAIT_LOAD | load accepted, waiting for dbus_rvalid
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_o_valid,
  input  logic [REG_AW-1:0] lsu_o_rd,
  input  logic              lsu_o_rf_we,
  input  logic [DATA_W-1:0] lsu_o_rd_dat,
  input  logic              lsu_o_is_load,
  input  logic [1:0]        lsu_o_ld_size,
  input  logic              lsu_o_ld_unsigned,
  input  logic [2:0]        lsu_o_addr_lo,
  input  logic [DATA_W-1:0] lsu_o_pc,
  output logic              wb_o_ready,
  input  logic              dbus_rvalid,
  input  logic [DATA_W-1:0] dbus_rdata,
  output logic [REG_AW-1:0] wb_i_rd,
  output logic              wb_i_rf_we,
  output logic [DATA_W-1:0] wb_i_rd_dat,
  output logic              wb_o_load_stall,
  output logic [REG_AW-1:0] wb_o_pend_rd
`ifdef WB_DIFFTEST_EN
  ,
  output logic              wb_o_commit,
  output logic [DATA_W-1:0] wb_o_commit_pc
`endif
);

  wb_state_e         state;
  logic [REG_AW-1:0] ld_rd;
  logic              ld_we;
  ld_size_e          ld_size;
  logic              ld_unsigned;
  logic [2:0]        ld_addr_lo;
  logic [DATA_W-1:0] ld_value;

`ifdef WB_DIFFTEST_EN
  logic [DATA_W-1:0] ld_pc;
`else
  logic              unused_pc;
  assign unused_pc = ^lsu_o_pc;
`endif

  assign wb_o_ready = (state == S_IDLE);

  wb_stage_load_align u_load_align (
    .rdata       (dbus_rdata),
    .addr_lo     (ld_addr_lo),
    .size        (ld_size),
    .is_unsigned (ld_unsigned),
    .value       (ld_value)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      ld_rd           <= '0;
      ld_we           <= 1'b0;
      ld_size         <= LD_B;
      ld_unsigned     <= 1'b0;
      ld_addr_lo      <= '0;
      wb_i_rd         <= '0;
      wb_i_rf_we      <= 1'b0;
      wb_i_rd_dat     <= '0;
      wb_o_load_stall <= 1'b0;
      wb_o_pend_rd    <= '0;
`ifdef WB_DIFFTEST_EN
      ld_pc           <= '0;
      wb_o_commit     <= 1'b0;
      wb_o_commit_pc  <= '0;
`endif
    end else begin
      // Write enable and commit are single-cycle pulses.
      wb_i_rf_we <= 1'b0;
`ifdef WB_DIFFTEST_EN
      wb_o_commit <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (lsu_o_valid) begin
            if (lsu_o_is_load) begin
              ld_rd           <= lsu_o_rd;
              ld_we           <= lsu_o_rf_we;
              ld_size         <= ld_size_e'(lsu_o_ld_size);
              ld_unsigned     <= lsu_o_ld_unsigned;
              ld_addr_lo      <= lsu_o_addr_lo;
              wb_o_load_stall <= 1'b1;
              wb_o_pend_rd    <= lsu_o_rd;
              state           <= S_WAIT_LOAD;
`ifdef WB_DIFFTEST_EN
              ld_pc           <= lsu_o_pc;
`endif
            end else begin
              wb_i_rd     <= lsu_o_rd;
              wb_i_rd_dat <= lsu_o_rd_dat;
              wb_i_rf_we  <= lsu_o_rf_we && (lsu_o_rd != '0);
`ifdef WB_DIFFTEST_EN
              wb_o_commit    <= 1'b1;
              wb_o_commit_pc <= lsu_o_pc;
`endif
            end
          end
        end
        S_WAIT_LOAD: begin
          if (dbus_rvalid) begin
            wb_i_rd         <= ld_rd;
            wb_i_rd_dat     <= ld_value;
            wb_i_rf_we      <= ld_we && (ld_rd != '0);
            wb_o_load_stall <= 1'b0;
            wb_o_pend_rd    <= '0;
            state           <= S_IDLE;
`ifdef WB_DIFFTEST_EN
            wb_o_commit    <= 1'b1;
            wb_o_commit_pc <= ld_pc;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: directed scenarios followed by randomized
// instruction streams checked against a behavioural load/write model.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_o_valid;
  logic [4:0]  lsu_o_rd;
  logic        lsu_o_rf_we;
  logic [63:0] lsu_o_rd_dat;
  logic        lsu_o_is_load;
  logic [1:0]  lsu_o_ld_size;
  logic        lsu_o_ld_unsigned;
  logic [2:0]  lsu_o_addr_lo;
  logic [63:0] lsu_o_pc;
  logic        wb_o_ready;
  logic        dbus_rvalid;
  logic [63:0] dbus_rdata;
  logic [4:0]  wb_i_rd;
  logic        wb_i_rf_we;
  logic [63:0] wb_i_rd_dat;
  logic        wb_o_load_stall;
  logic [4:0]  wb_o_pend_rd;
`ifdef WB_DIFFTEST_EN
  logic        wb_o_commit;
  logic [63:0] wb_o_commit_pc;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk               (clk),
    .rst               (rst),
    .lsu_o_valid       (lsu_o_valid),
    .lsu_o_rd          (lsu_o_rd),
    .lsu_o_rf_we       (lsu_o_rf_we),
    .lsu_o_rd_dat      (lsu_o_rd_dat),
    .lsu_o_is_load     (lsu_o_is_load),
    .lsu_o_ld_size     (lsu_o_ld_size),
    .lsu_o_ld_unsigned (lsu_o_ld_unsigned),
    .lsu_o_addr_lo     (lsu_o_addr_lo),
    .lsu_o_pc          (lsu_o_pc),
    .wb_o_ready        (wb_o_ready),
    .dbus_rvalid       (dbus_rvalid),
    .dbus_rdata        (dbus_rdata),
    .wb_i_rd           (wb_i_rd),
    .wb_i_rf_we        (wb_i_rf_we),
    .wb_i_rd_dat       (wb_i_rd_dat),
    .wb_o_load_stall   (wb_o_load_stall),
    .wb_o_pend_rd      (wb_o_pend_rd)
`ifdef WB_DIFFTEST_EN
    ,
    .wb_o_commit       (wb_o_commit),
    .wb_o_commit_pc    (wb_o_commit_pc)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference load result computed arithmetically: shift the addressed
  // bytes down, mask to the access width, and fill the upper bits with the
  // sign bit for signed loads.
  function automatic logic [63:0] ref_load(input logic [63:0] rdata, input logic [2:0] addr,
                                           input logic [1:0] size, input logic uns);
    int unsigned nbytes;
    int unsigned off;
    logic [63:0] v;
    logic [63:0] mask;
    nbytes = 1 << size;
    off    = (size == 2'd3) ? 0 : (int'(addr) / nbytes) * nbytes;
    v      = rdata >> (8 * off);
    mask   = (nbytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nbytes)) - 64'd1);
    v      = v & mask;
    if (!uns && v[8 * nbytes - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic offer(input logic load, input logic [4:0] rd, input logic we,
                       input logic [63:0] dat, input logic [1:0] size, input logic uns,
                       input logic [2:0] addr);
    lsu_o_valid       = 1'b1;
    lsu_o_is_load     = load;
    lsu_o_rd          = rd;
    lsu_o_rf_we       = we;
    lsu_o_rd_dat      = dat;
    lsu_o_ld_size     = size;
    lsu_o_ld_unsigned = uns;
    lsu_o_addr_lo     = addr;
    lsu_o_pc          = {$urandom, $urandom};
  endtask

  task automatic chk_write(input string tag, input logic [4:0] rd, input logic we,
                           input logic [63:0] dat);
    logic exp_we;
    exp_we = we && (rd != 5'd0);
    chk({tag, "_we"}, 64'(wb_i_rf_we), 64'(exp_we));
    chk({tag, "_rd"}, 64'(wb_i_rd), 64'(rd));
    chk({tag, "_dat"}, wb_i_rd_dat, dat);
`ifdef WB_DIFFTEST_EN
    chk({tag, "_commit"}, 64'(wb_o_commit), 64'd1);
`endif
  endtask

  initial begin
    logic [63:0] rdata;
    logic [63:0] pc_hold;
    rst = 1'b1;
    lsu_o_valid = 1'b0; lsu_o_rd = '0; lsu_o_rf_we = 1'b0; lsu_o_rd_dat = '0;
    lsu_o_is_load = 1'b0; lsu_o_ld_size = '0; lsu_o_ld_unsigned = 1'b0;
    lsu_o_addr_lo = '0; lsu_o_pc = '0; dbus_rvalid = 1'b0; dbus_rdata = '0;
    pc_hold = '0;

    // Reset values
    #2;
    chk("rst_we", 64'(wb_i_rf_we), 64'd0);
    chk("rst_rd", 64'(wb_i_rd), 64'd0);
    chk("rst_dat", wb_i_rd_dat, 64'd0);
    chk("rst_stall", 64'(wb_o_load_stall), 64'd0);
    chk("rst_pend", 64'(wb_o_pend_rd), 64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_ready", 64'(wb_o_ready), 64'd1);

    // Non-load write, then single-cycle pulse
    offer(1'b0, 5'd5, 1'b1, 64'h1234, 2'd0, 1'b0, 3'd0);
    tick();
    lsu_o_valid = 1'b0;
    chk_write("nl", 5'd5, 1'b1, 64'h1234);
    tick();
    chk("nl_pulse", 64'(wb_i_rf_we), 64'd0);
    chk("nl_hold", wb_i_rd_dat, 64'h1234);

    // rd=0 never written
    offer(1'b0, 5'd0, 1'b1, 64'hDEAD, 2'd0, 1'b0, 3'd0);
    tick();
    lsu_o_valid = 1'b0;
    chk_write("x0", 5'd0, 1'b1, 64'hDEAD);

    // Back-to-back non-loads
    offer(1'b0, 5'd1, 1'b1, 64'hA1, 2'd0, 1'b0, 3'd0);
    tick();
    chk_write("b2b0", 5'd1, 1'b1, 64'hA1);
    offer(1'b0, 5'd2, 1'b1, 64'hB2, 2'd0, 1'b0, 3'd0);
    tick();
    lsu_o_valid = 1'b0;
    chk_write("b2b1", 5'd2, 1'b1, 64'hB2);

    // Signed and unsigned byte loads from lane 3
    for (int u = 0; u < 2; u++) begin
      offer(1'b1, 5'd7, 1'b1, 64'h0, 2'd0, u[0], 3'd3);
      tick();
      lsu_o_valid = 1'b0;
      chk("lb_ready", 64'(wb_o_ready), 64'd0);
      chk("lb_pend", 64'(wb_o_pend_rd), 64'd7);
      dbus_rvalid = 1'b1;
      dbus_rdata  = 64'h0000_0000_8000_0000;
      tick();
      dbus_rvalid = 1'b0;
      chk_write(u == 0 ? "lb_s" : "lb_u", 5'd7, 1'b1,
                u == 0 ? 64'hFFFF_FFFF_FFFF_FF80 : 64'h80);
    end

    // Delayed rvalid: stall held for four cycles, rvalid in accept cycle ignored
    offer(1'b1, 5'd9, 1'b1, 64'h0, 2'd2, 1'b0, 3'd4);
    dbus_rvalid = 1'b1;
    dbus_rdata  = 64'h1111_1111_2222_2222;
    tick();
    lsu_o_valid = 1'b0;
    dbus_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("st_we", 64'(wb_i_rf_we), 64'd0);
      chk("st_ready", 64'(wb_o_ready), 64'd0);
      chk("st_stall", 64'(wb_o_load_stall), 64'd1);
      chk("st_pend", 64'(wb_o_pend_rd), 64'd9);
      tick();
    end
    dbus_rvalid = 1'b1;
    dbus_rdata  = 64'h8765_4321_0000_0001;
    tick();
    dbus_rvalid = 1'b0;
    chk_write("st_lw", 5'd9, 1'b1, 64'hFFFF_FFFF_8765_4321);
    chk("st_unstall", 64'(wb_o_load_stall), 64'd0);
    tick();
    chk("st_pulse", 64'(wb_i_rf_we), 64'd0);

    // Stray rvalid in IDLE
    dbus_rvalid = 1'b1;
    dbus_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    dbus_rvalid = 1'b0;
    chk("stray_we", 64'(wb_i_rf_we), 64'd0);
    chk("stray_ready", 64'(wb_o_ready), 64'd1);

    // Reset during WAIT_LOAD drops the load
    offer(1'b1, 5'd12, 1'b1, 64'h0, 2'd3, 1'b0, 3'd0);
    tick();
    lsu_o_valid = 1'b0;
    chk("rw_stall", 64'(wb_o_load_stall), 64'd1);
    rst = 1'b1;
    #1;
    chk("rw_stall0", 64'(wb_o_load_stall), 64'd0);
    chk("rw_pend0", 64'(wb_o_pend_rd), 64'd0);
    chk("rw_dat0", wb_i_rd_dat, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    dbus_rvalid = 1'b1;
    dbus_rdata  = 64'h5555_5555_5555_5555;
    tick();
    dbus_rvalid = 1'b0;
    chk("rw_we", 64'(wb_i_rf_we), 64'd0);
    chk("rw_rd", 64'(wb_i_rd), 64'd0);
    chk("rw_ready", 64'(wb_o_ready), 64'd1);

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      logic        is_ld;
      logic [4:0]  rd;
      logic        we;
      logic [63:0] dat;
      logic [1:0]  sz;
      logic        uns;
      logic [2:0]  addr;
      int          dly;
      is_ld = ($urandom_range(0, 1) == 1);
      rd    = 5'($urandom_range(0, 31));
      we    = ($urandom_range(0, 3) != 0);
      dat   = {$urandom, $urandom};
      sz    = 2'($urandom_range(0, 3));
      uns   = $urandom_range(0, 1) == 1;
      addr  = 3'($urandom_range(0, 7));
      if (sz != 2'd3) addr = 3'((int'(addr) / (1 << sz)) * (1 << sz));
      chk("r_ready", 64'(wb_o_ready), 64'd1);
      offer(is_ld, rd, we, dat, sz, uns, addr);
      tick();
      if (!is_ld) begin
        if ($urandom_range(0, 1) == 1) lsu_o_valid = 1'b0;
        chk_write("r_nl", rd, we, dat);
      end else begin
        chk("r_acc_we", 64'(wb_i_rf_we), 64'd0);
        // Keep offering junk non-loads while waiting; none may be accepted.
        offer(1'b0, 5'd31, 1'b1, 64'hBAD, 2'd0, 1'b0, 3'd0);
        dly = $urandom_range(0, 3);
        for (int d = 0; d < dly; d++) begin
          chk("r_stall", 64'(wb_o_load_stall), 64'd1);
          chk("r_pend", 64'(wb_o_pend_rd), 64'(rd));
          chk("r_wait_we", 64'(wb_i_rf_we), 64'd0);
          tick();
        end
        rdata       = {$urandom, $urandom};
        dbus_rvalid = 1'b1;
        dbus_rdata  = rdata;
        tick();
        dbus_rvalid = 1'b0;
        lsu_o_valid = 1'b0;
        chk_write("r_ld", rd, we, ref_load(rdata, addr, sz, uns));
      end
      if ($urandom_range(0, 3) == 0) begin
        lsu_o_valid = 1'b0;
        tick();
        chk("r_idle_we", 64'(wb_i_rf_we), 64'd0);
      end
    end
    lsu_o_valid = 1'b0;
    tick();
    pc_hold = lsu_o_pc;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
